// File: rtl/stimulus_sequencer_if.sv
// Bus between bench/host control and the stimulus sequencer: step writes, playback
// control and the replayed vector with its status flags.
interface stimulus_sequencer_if #(
   parameter int unsigned CHANNELS = 6,
   parameter int unsigned WIDTH    = 17,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned HOLD_W   = 8,
   parameter int unsigned LEN_W    = $clog2(DEPTH + 1),
   parameter int unsigned ADDR_W   = $clog2(DEPTH)
);
   logic                      wr_en;
   logic [ADDR_W-1:0]         wr_addr;
   logic [CHANNELS*WIDTH-1:0] wr_data;
   logic [HOLD_W-1:0]         wr_hold;
   logic [LEN_W-1:0]          len;
   logic                      start;
   logic                      stop;
   logic                      loop_en;
   logic [CHANNELS*WIDTH-1:0] out_vec;
   logic [ADDR_W-1:0]         step_idx;
   logic                      step_strobe;
   logic                      busy;
   logic                      done;

   modport master (
      output wr_en, wr_addr, wr_data, wr_hold, len, start, stop, loop_en,
      input  out_vec, step_idx, step_strobe, busy, done
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_hold, len, start, stop, loop_en,
      output out_vec, step_idx, step_strobe, busy, done
   );
endinterface

// File: rtl/stimulus_sequencer.sv
// Vector player: stores up to DEPTH (vector, hold) steps and replays them back-to-back,
// with stop, live loop control, a per-step strobe and a completion pulse.
module stimulus_sequencer #(
   parameter int unsigned CHANNELS = 6,
   parameter int unsigned WIDTH    = 17,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned HOLD_W   = 8,
   parameter int unsigned LEN_W    = $clog2(DEPTH + 1),
   parameter int unsigned ADDR_W   = $clog2(DEPTH)
) (
   input logic             clk,
   input logic             rst_n,
   stimulus_sequencer_if.slave bus
);
   localparam int unsigned VEC_W = CHANNELS * WIDTH;

   typedef enum logic [0:0] {StIdle, StPlay} state_e;

   state_e             state_q, state_d;
   logic [VEC_W-1:0]   out_q, out_d;
   logic [ADDR_W-1:0]  idx_q, idx_d;
   logic [HOLD_W-1:0]  cnt_q, cnt_d;
   logic [LEN_W-1:0]   eff_len_q, eff_len_d;
   logic               strobe_q, strobe_d;
   logic               done_q, done_d;

   logic [VEC_W-1:0]   data_mem [DEPTH];
   logic [HOLD_W-1:0]  hold_mem [DEPTH];

   logic               wr_ok;
   logic               wr_hits_0;
   logic [VEC_W-1:0]   first_vec;
   logic [HOLD_W-1:0]  first_hold;
   logic [ADDR_W-1:0]  nxt_idx;
   logic               last_step;

   assign wr_ok      = bus.wr_en && (state_q == StIdle);
   // A write to step 0 in the start cycle must be visible to the first applied vector.
   assign wr_hits_0  = wr_ok && (bus.wr_addr == '0);
   assign first_vec  = wr_hits_0 ? bus.wr_data : data_mem[0];
   assign first_hold = wr_hits_0 ? bus.wr_hold : hold_mem[0];
   assign nxt_idx    = idx_q + ADDR_W'(1);
   assign last_step  = (LEN_W'(idx_q) + LEN_W'(1)) == eff_len_q;

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         data_mem[bus.wr_addr] <= bus.wr_data;
         hold_mem[bus.wr_addr] <= bus.wr_hold;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         out_q     <= '0;
         idx_q     <= '0;
         cnt_q     <= '0;
         eff_len_q <= '0;
         strobe_q  <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         out_q     <= out_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         eff_len_q <= eff_len_d;
         strobe_q  <= strobe_d;
         done_q    <= done_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      out_d     = out_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      eff_len_d = eff_len_q;
      strobe_d  = 1'b0;
      done_d    = 1'b0;
      case (state_q)
         StIdle: begin
            if (bus.start && !bus.stop && (bus.len != '0)) begin
               state_d   = StPlay;
               out_d     = first_vec;
               idx_d     = '0;
               cnt_d     = first_hold;
               eff_len_d = (bus.len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : bus.len;
               strobe_d  = 1'b1;
            end
         end
         StPlay: begin
            if (bus.stop) begin
               state_d = StIdle;
               out_d   = '0;
               idx_d   = '0;
               cnt_d   = '0;
            end else if (cnt_q != '0) begin
               cnt_d = cnt_q - HOLD_W'(1);
            end else if (!last_step) begin
               idx_d    = nxt_idx;
               out_d    = data_mem[nxt_idx];
               cnt_d    = hold_mem[nxt_idx];
               strobe_d = 1'b1;
            end else if (bus.loop_en) begin
               idx_d    = '0;
               out_d    = data_mem[0];
               cnt_d    = hold_mem[0];
               strobe_d = 1'b1;
            end else begin
               state_d = StIdle;
               done_d  = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.out_vec     = out_q;
   assign bus.step_idx    = idx_q;
   assign bus.step_strobe = strobe_q;
   assign bus.busy        = (state_q == StPlay);
   assign bus.done        = done_q;
endmodule

// File: tb/tb_stimulus_sequencer.sv
// Randomized bench for stimulus_sequencer: expected per-cycle traces are expanded from a
// model memory (each step repeated hold+1 times) and compared cycle by cycle.
module tb_stimulus_sequencer;
   localparam int CHANNELS = 6;
   localparam int WIDTH    = 17;
   localparam int DEPTH    = 8;
   localparam int HOLD_W   = 8;
   localparam int LEN_W    = 4;
   localparam int ADDR_W   = 3;
   localparam int CW       = CHANNELS * WIDTH;
   localparam int VW       = CW + ADDR_W + 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   stimulus_sequencer_if #(
      .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH),
      .HOLD_W(HOLD_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)
   ) bus ();

   stimulus_sequencer #(
      .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH),
      .HOLD_W(HOLD_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int unsigned n_cmp = 0;
   int unsigned n_err = 0;

   logic [CW-1:0]     m_data [DEPTH];
   logic [HOLD_W-1:0] m_hold [DEPTH];
   logic [CW-1:0]     exp_out;
   logic [ADDR_W-1:0] exp_idx;

   task automatic check_eq(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [VW-1:0] observed();
      return {bus.out_vec, bus.step_idx, bus.step_strobe, bus.busy, bus.done};
   endfunction

   function automatic logic [VW-1:0] idle_vec();
      return {exp_out, exp_idx, 3'b000};
   endfunction

   function automatic logic [CW-1:0] rand_vec();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return r[CW-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic write_step(input int a, input logic [CW-1:0] d, input int h);
      bus.wr_en   = 1'b1;
      bus.wr_addr = ADDR_W'(a);
      bus.wr_data = d;
      bus.wr_hold = HOLD_W'(h);
      tick();
      bus.wr_en   = 1'b0;
      m_data[a]   = d;
      m_hold[a]   = HOLD_W'(h);
   endtask

   // Start playback of len_v steps and check every cycle. passes>1 runs in loop mode and
   // drops loop_en during the final pass. stop_at/rst_at/wr_at are trace indices (-1 = off).
   task automatic play(input int len_v, input int passes, input int stop_at,
                       input int rst_at, input int wr_at);
      logic [VW-1:0] trace[$];
      int eff, cpp, drop_at;
      eff = (len_v > DEPTH) ? DEPTH : len_v;
      cpp = 0;
      for (int i = 0; i < eff; i++) cpp += int'(m_hold[i]) + 1;
      for (int p = 0; p < passes; p++)
         for (int i = 0; i < eff; i++)
            for (int c = 0; c <= int'(m_hold[i]); c++)
               trace.push_back({m_data[i], ADDR_W'(i), (c == 0), 1'b1, 1'b0});
      drop_at = (passes > 1) ? (passes - 1) * cpp + ((eff > 1) ? int'(m_hold[0]) + 1 : 0) : -1;
      bus.loop_en = (passes > 1);
      bus.len     = LEN_W'(len_v);
      bus.start   = 1'b1;
      tick();
      bus.start   = 1'b0;
      bus.wr_en   = 1'b0;
      for (int j = 0; j < trace.size(); j++) begin
         check_eq("play", observed(), trace[j]);
         bus.wr_en = 1'b0;
         if (j == drop_at) bus.loop_en = 1'b0;
         if (j == stop_at) begin
            bus.stop = 1'b1;
            tick();
            bus.stop    = 1'b0;
            bus.loop_en = 1'b0;
            exp_out = '0;
            exp_idx = '0;
            check_eq("stop", observed(), idle_vec());
            tick();
            check_eq("stop_idle", observed(), idle_vec());
            return;
         end
         if (j == rst_at) begin
            rst_n = 1'b0;
            #2;
            exp_out = '0;
            exp_idx = '0;
            check_eq("async_rst", observed(), idle_vec());
            bus.loop_en = 1'b0;
            tick();
            rst_n = 1'b1;
            tick();
            check_eq("rst_idle", observed(), idle_vec());
            return;
         end
         if (j == wr_at) begin
            bus.wr_en   = 1'b1;
            bus.wr_addr = ADDR_W'($urandom_range(DEPTH - 1));
            bus.wr_data = rand_vec();
            bus.wr_hold = HOLD_W'($urandom_range(255));
         end
         tick();
      end
      bus.wr_en   = 1'b0;
      bus.loop_en = 1'b0;
      exp_out = m_data[eff-1];
      exp_idx = ADDR_W'(eff - 1);
      check_eq("done", observed(), {exp_out, exp_idx, 3'b001});
      tick();
      check_eq("idle_after", observed(), idle_vec());
   endtask

   logic [WIDTH-1:0] dflt_v [7] = '{17'h00000, 17'h000FF, 17'h00000, 17'h0FF00,
                                    17'h00000, 17'h0FF00, 17'h1FFFF};
   int               dflt_h [7] = '{1, 3, 5, 7, 9, 11, 0};

   initial begin
      logic [WIDTH-1:0] v;
      int rst_at, stop_at, wr_at;
      rst_n       = 1'b0;
      bus.wr_en   = 1'b0;
      bus.wr_addr = '0;
      bus.wr_data = '0;
      bus.wr_hold = '0;
      bus.len     = '0;
      bus.start   = 1'b0;
      bus.stop    = 1'b0;
      bus.loop_en = 1'b0;
      exp_out     = '0;
      exp_idx     = '0;
      repeat (2) tick();
      check_eq("reset", observed(), idle_vec());
      rst_n = 1'b1;
      tick();
      for (int a = 0; a < DEPTH; a++) write_step(a, rand_vec(), $urandom_range(6));
      check_eq("idle_writes", observed(), idle_vec());

      // Reference vector set replicated on every channel.
      for (int a = 0; a < 7; a++) begin
         v = dflt_v[a];
         write_step(a, {CHANNELS{v}}, dflt_h[a]);
      end
      play(7, 1, -1, -1, -1);

      for (int a = 0; a < 3; a++) write_step(a, rand_vec(), 0);
      play(3, 2, -1, -1, -1);

      write_step(0, rand_vec(), 9);
      play(3, 1, 2, -1, 0);
      play(3, 1, -1, -1, -1);

      bus.len   = '0;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      check_eq("len0", observed(), idle_vec());
      bus.len   = LEN_W'(3);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      tick();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      check_eq("start_stop", observed(), idle_vec());

      play(15, 1, -1, -1, -1);

      bus.wr_en   = 1'b1;
      bus.wr_addr = '0;
      bus.wr_data = '1;
      bus.wr_hold = HOLD_W'(2);
      m_data[0]   = '1;
      m_hold[0]   = HOLD_W'(2);
      play(4, 1, -1, -1, -1);

      write_step(2, rand_vec(), 3);
      rst_at = int'(m_hold[0]) + int'(m_hold[1]) + 3;
      play(5, 1, -1, rst_at, -1);
      play(5, 1, -1, -1, -1);

      for (int it = 0; it < 25; it++) begin
         for (int k = int'($urandom_range(3)); k > 0; k--)
            write_step($urandom_range(DEPTH - 1), rand_vec(), $urandom_range(6));
         stop_at = ($urandom_range(3) == 0) ? int'($urandom_range(40)) : -1;
         wr_at   = ($urandom_range(2) == 0) ? int'($urandom_range(20)) : -1;
         play(1 + $urandom_range(14), 1 + $urandom_range(2), stop_at, -1, wr_at);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
